// File: rtl/wm_input_conditioner.sv
// rtl/wm_input_conditioner.sv - synchronize and debounce washing-machine front-panel inputs
//
// Purpose: two-flop synchronizes every raw panel input, then debounces the
// start/pause button, the 2-bit mode selector (as one vector) and the door
// switch, each with its own counter, and turns the debounced button into
// single-cycle command pulses.
//
// Parameters:
//   DEBOUNCE_CYCLES   - consecutive mismatching synced samples before the
//                       debounced value follows (2..65535)
//   LONG_PRESS_CYCLES - debounced-high duration that counts as a long press
//                       (2..2^24-1); only used when WM_LONG_PRESS_EN is set
//
// Ports:
//   clk             in   system clock, rising edge
//   reset           in   asynchronous active-high reset
//   start_pause_raw in   raw start/pause button, 1 = pressed
//   mode_raw[1:0]   in   raw mode selector
//   door_raw        in   raw door switch
//   start_pause     out  single-cycle press pulse
//   mode_select     out  debounced mode
//   door_sensor     out  debounced door level
//   cancel          out  single-cycle long-press pulse (0 unless WM_LONG_PRESS_EN)
//
// Optional feature macro: WM_LONG_PRESS_EN
//   undefined: start_pause pulses one cycle after the debounced press; cancel = 0
//   defined:   cancel pulses on a long press; start_pause pulses one cycle after
//              the debounced release of a press that did not raise cancel

module wm_input_conditioner #(
  parameter int DEBOUNCE_CYCLES   = 16,
  parameter int LONG_PRESS_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_pause_raw,
  input  logic [1:0] mode_raw,
  input  logic       door_raw,
  output logic       start_pause,
  output logic [1:0] mode_select,
  output logic       door_sensor,
  output logic       cancel
);

  localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 1);

  // Synchronizer vector layout: {button, mode[1:0], door}
  logic [3:0]  sync1_q, sync2_q;
  logic        btn_s, door_s;
  logic [1:0]  mode_s;

  logic        btn_db_q, btn_db_d;
  logic [1:0]  mode_db_q, mode_db_d;
  logic        door_db_q, door_db_d;
  logic [15:0] btn_cnt_q, btn_cnt_d;
  logic [15:0] mode_cnt_q, mode_cnt_d;
  logic [15:0] door_cnt_q, door_cnt_d;
  logic [1:0]  mode_prev_q;
  logic        btn_dly_q;
  logic        start_pause_q, start_pause_d;

  assign btn_s  = sync2_q[3];
  assign mode_s = sync2_q[2:1];
  assign door_s = sync2_q[0];

  always_comb begin
    btn_db_d   = btn_db_q;
    btn_cnt_d  = '0;
    mode_db_d  = mode_db_q;
    mode_cnt_d = '0;
    door_db_d  = door_db_q;
    door_cnt_d = '0;

    if (btn_s != btn_db_q) begin
      if (btn_cnt_q == DB_LAST) btn_db_d = btn_s;
      else                      btn_cnt_d = btn_cnt_q + 16'd1;
    end

    // A fresh synced mode value restarts the count at 1: that sample is the
    // first one of the new candidate, so a mid-count change costs full latency.
    if (mode_s != mode_db_q) begin
      if (mode_s != mode_prev_q)       mode_cnt_d = 16'd1;
      else if (mode_cnt_q == DB_LAST)  mode_db_d  = mode_s;
      else                             mode_cnt_d = mode_cnt_q + 16'd1;
    end

    if (door_s != door_db_q) begin
      if (door_cnt_q == DB_LAST) door_db_d = door_s;
      else                       door_cnt_d = door_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      btn_db_q      <= 1'b0;
      mode_db_q     <= 2'b00;
      door_db_q     <= 1'b0;
      btn_cnt_q     <= '0;
      mode_cnt_q    <= '0;
      door_cnt_q    <= '0;
      mode_prev_q   <= 2'b00;
      btn_dly_q     <= 1'b0;
      start_pause_q <= 1'b0;
    end else begin
      sync1_q       <= {start_pause_raw, mode_raw, door_raw};
      sync2_q       <= sync1_q;
      btn_db_q      <= btn_db_d;
      mode_db_q     <= mode_db_d;
      door_db_q     <= door_db_d;
      btn_cnt_q     <= btn_cnt_d;
      mode_cnt_q    <= mode_cnt_d;
      door_cnt_q    <= door_cnt_d;
      mode_prev_q   <= mode_s;
      btn_dly_q     <= btn_db_q;
      start_pause_q <= start_pause_d;
    end
  end

`ifdef WM_LONG_PRESS_EN
  localparam logic [23:0] LP_MAX = 24'(LONG_PRESS_CYCLES);

  logic [23:0] press_cnt_q, press_cnt_d;
  logic        fired_q, fired_d;
  logic        cancel_q, cancel_d;

  always_comb begin
    press_cnt_d = '0;
    if (btn_db_d) begin
      press_cnt_d = (press_cnt_q == LP_MAX) ? press_cnt_q : press_cnt_q + 24'd1;
    end
    // Counter saturates at LP_MAX; fired_q keeps cancel to one pulse per press.
    cancel_d      = (press_cnt_q == LP_MAX) && !fired_q;
    // fired_q survives the falling edge so the release decision can still see it.
    fired_d       = btn_db_q ? (fired_q | cancel_d) : 1'b0;
    start_pause_d = btn_dly_q & ~btn_db_q & ~fired_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      press_cnt_q <= '0;
      fired_q     <= 1'b0;
      cancel_q    <= 1'b0;
    end else begin
      press_cnt_q <= press_cnt_d;
      fired_q     <= fired_d;
      cancel_q    <= cancel_d;
    end
  end

  assign cancel = cancel_q;
`else
  always_comb begin
    start_pause_d = btn_db_q & ~btn_dly_q;
  end

  assign cancel = 1'b0;
`endif

  assign start_pause = start_pause_q;
  assign mode_select = mode_db_q;
  assign door_sensor = door_db_q;

endmodule

// File: tb/tb_wm_input_conditioner.sv
// tb/tb_wm_input_conditioner.sv - self-checking bench for wm_input_conditioner

module tb_wm_input_conditioner;

  localparam int D = 4;
  localparam int L = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       door = 1'b0;
  logic       start_pause, door_sensor, cancel;
  logic [1:0] mode_select;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  wm_input_conditioner #(.DEBOUNCE_CYCLES(D), .LONG_PRESS_CYCLES(L)) dut (
    .clk(clk), .reset(reset), .start_pause_raw(btn), .mode_raw(mode),
    .door_raw(door), .start_pause(start_pause), .mode_select(mode_select),
    .door_sensor(door_sensor), .cancel(cancel)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: a debounced value follows once the last D synced samples agree
  // with each other and differ from it; synced sample = raw two edges back.
  logic [3:0] pipe0, pipe1, smp;
  logic [3:0] hist[$];
  logic       m_btn, m_door, m_sp, m_cancel, old_btn;
  logic [1:0] m_mode;
  bit         b_ok, m_ok, d_ok, fired;
  int         em, rise_at, fall_at;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe0 = '0; pipe1 = '0; hist.delete();
      m_btn = 0; m_door = 0; m_mode = 2'b00; m_sp = 0; m_cancel = 0;
      em = 0; rise_at = -100; fall_at = -100; fired = 0;
    end else begin
      em = em + 1;
      old_btn = m_btn;
      m_sp = 0;
      m_cancel = 0;
`ifdef WM_LONG_PRESS_EN
      if (old_btn && (em - rise_at) == L) begin m_cancel = 1; fired = 1; end
      if (em == fall_at + 1 && !fired) m_sp = 1;
`else
      if (em == rise_at + 1) m_sp = 1;
`endif
      smp = pipe1;
      pipe1 = pipe0;
      pipe0 = {btn, mode, door};
      hist.push_back(smp);
      if (hist.size() > D) void'(hist.pop_front());
      if (hist.size() == D) begin
        b_ok = 1; m_ok = 1; d_ok = 1;
        for (int i = 0; i < D; i++) begin
          if (hist[i][3]   != smp[3])   b_ok = 0;
          if (hist[i][2:1] != smp[2:1]) m_ok = 0;
          if (hist[i][0]   != smp[0])   d_ok = 0;
        end
        if (b_ok && smp[3] != m_btn) begin
          m_btn = smp[3];
          if (m_btn) begin rise_at = em; fired = 0; end
          else fall_at = em;
        end
        if (m_ok) m_mode = smp[2:1];
        if (d_ok) m_door = smp[0];
      end
    end
  end

  // Per-cycle compare against the model, plus event logging for literal checks.
  int sp_cnt, sp_at, ca_cnt, ca_at;
  bit saw11;

  always @(negedge clk) begin
    if (cmp_en) begin
      check("start_pause", 32'(start_pause), 32'(m_sp));
      check("cancel", 32'(cancel), 32'(m_cancel));
      check("mode_select", 32'(mode_select), 32'(m_mode));
      check("door_sensor", 32'(door_sensor), 32'(m_door));
    end
    if (start_pause === 1'b1) begin sp_cnt++; sp_at = cyc; end
    if (cancel === 1'b1) begin ca_cnt++; ca_at = cyc; end
    if (mode_select === 2'b11) saw11 = 1;
  end

  task automatic clr_mon();
    sp_cnt = 0; sp_at = -1; ca_cnt = 0; ca_at = -1; saw11 = 0;
  endtask

  task automatic wait_mode(input logic [1:0] v, output int edge_n);
    edge_n = -1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (mode_select === v) begin edge_n = i; break; end
    end
  endtask

  task automatic wait_door(output int edge_n);
    edge_n = -1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (door_sensor === 1'b1) begin edge_n = i; break; end
    end
  endtask

  int t0, e;

  initial begin
    clr_mon();
    #1;
    check("reset_sp", 32'(start_pause), 0);
    check("reset_mode", 32'(mode_select), 0);
    check("reset_door", 32'(door_sensor), 0);
    check("reset_cancel", 32'(cancel), 0);
    repeat (2) @(negedge clk);
    cmp_en = 1'b1;
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Button held 10 cycles
    clr_mon();
    btn = 1'b1; t0 = cyc;
    repeat (10) @(negedge clk);
    btn = 1'b0;
    repeat (15) @(negedge clk);
    check("hold10_sp_count", 32'(sp_cnt), 1);
    check("hold10_cancel_count", 32'(ca_cnt), 0);
`ifdef WM_LONG_PRESS_EN
    check("hold10_sp_edge", 32'(sp_at - t0), 17);
`else
    check("hold10_sp_edge", 32'(sp_at - t0), 7);
`endif
    check("hold10_mode", 32'(mode_select), 0);
    check("hold10_door", 32'(door_sensor), 0);

    // Short glitch, then bounce ending high
    clr_mon();
    btn = 1'b1;
    repeat (3) @(negedge clk);
    btn = 1'b0;
    repeat (12) @(negedge clk);
    check("glitch_no_sp", 32'(sp_cnt), 0);
    for (int i = 0; i < 6; i++) begin
      btn = (i % 2 == 0);
      @(negedge clk);
    end
    btn = 1'b1; t0 = cyc;
    repeat (12) @(negedge clk);
`ifndef WM_LONG_PRESS_EN
    check("bounce_sp_count", 32'(sp_cnt), 1);
    check("bounce_sp_edge", 32'(sp_at - t0), 7);
`endif
    btn = 1'b0;
    repeat (15) @(negedge clk);

`ifdef WM_LONG_PRESS_EN
    // Long press: cancel only, nothing on release
    clr_mon();
    btn = 1'b1; t0 = cyc;
    repeat (30) @(negedge clk);
    btn = 1'b0;
    repeat (15) @(negedge clk);
    check("long_cancel_count", 32'(ca_cnt), 1);
    check("long_cancel_edge", 32'(ca_at - t0), 26);
    check("long_no_sp", 32'(sp_cnt), 0);
`endif

    // Mode 00 -> 10
    clr_mon();
    mode = 2'b10;
    wait_mode(2'b10, e);
    check("mode10_edge", 32'(e), 6);
    repeat (4) @(negedge clk);
    // Mode 10 -> 11 for 2 cycles -> 01
    mode = 2'b11;
    repeat (2) @(negedge clk);
    mode = 2'b01;
    wait_mode(2'b01, e);
    check("mode01_edge", 32'(e), 6);
    check("mode_never_11", 32'(saw11), 0);
    repeat (4) @(negedge clk);

    // Door high, reset mid-count
    door = 1'b1;
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("door_reset_async", 32'(door_sensor), 0);
    check("mode_reset_async", 32'(mode_select), 0);
    repeat (2) @(negedge clk);
    check("door_in_reset", 32'(door_sensor), 0);
    clr_mon();
    reset = 1'b0;
    wait_door(e);
    check("door_after_reset_edge", 32'(e), 6);
    check("door_no_sp", 32'(sp_cnt), 0);
    repeat (6) @(negedge clk);

    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/wm_input_conditioner.md
WM_INPUT_CONDITIONER -- requirements
Module: wm_input_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16, consecutive synchronized samples a raw input must differ from its debounced value before the debounced value updates; legal range 2..65535.
REQ-002 Parameter LONG_PRESS_CYCLES, default 1000, debounced-high duration of the start/pause button that constitutes a long press; legal range 2..2^24-1; used only under WM_LONG_PRESS_EN.
REQ-003 clk  input  1  single system clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start_pause_raw  input  1  raw start/pause pushbutton, asynchronous, bouncy, 1 = pressed.
REQ-006 mode_raw  input  2  raw mode selector switch, asynchronous, bouncy.
REQ-007 door_raw  input  1  raw door switch, asynchronous, bouncy.
REQ-008 start_pause  output  1  single-cycle press pulse, drives the controller's start_pause.
REQ-009 mode_select  output  2  debounced mode, drives the controller's mode_select.
REQ-010 door_sensor  output  1  debounced door level, same polarity as door_raw.
REQ-011 cancel  output  1  single-cycle long-press pulse; constant 0 without WM_LONG_PRESS_EN.

Function
REQ-012 Each raw input SHALL pass through a 2-flop synchronizer; no logic SHALL read a raw input directly.
REQ-013 Channels (button, mode as one 2-bit vector, door) SHALL be debounced independently, each with its own counter.
REQ-014 Per channel: synced != debounced increments counter; synced == debounced clears counter; on the edge where counter == DEBOUNCE_CYCLES-1 and mismatch persists, debounced <= synced and counter clears.
REQ-015 The mode vector SHALL update only as a whole; any change of synced mode value during counting SHALL restart the count.
REQ-016 Latency, edge 1 = first edge sampling new raw value: debounced value (mode_select, door_sensor, internal button) changes at edge DEBOUNCE_CYCLES+2.
REQ-017 Without WM_LONG_PRESS_EN, start_pause SHALL be registered high for exactly one cycle on the edge after the debounced button goes 0->1 (edge DEBOUNCE_CYCLES+3); releases produce nothing.
REQ-018 At most one start_pause pulse per debounced press; bounce shorter than DEBOUNCE_CYCLES samples SHALL produce no pulse and no output change.
REQ-019 All outputs SHALL be registered; no combinational path from input to output.

Reset
REQ-020 reset SHALL asynchronously clear synchronizers, counters, debounced values and all outputs to 0 (start_pause=0, mode_select=2'b00, door_sensor=0, cancel=0).
REQ-021 reset mid-debounce or mid-press SHALL discard the pending change; after release, an input already non-zero SHALL be treated as a new change requiring the full REQ-016 latency.
REQ-022 No pulse SHALL be generated by reset assertion or deassertion itself.

Configuration
REQ-023 Macro WM_LONG_PRESS_EN: when defined, a press-duration counter SHALL count cycles the debounced button is high, saturating at LONG_PRESS_CYCLES, clearing when it goes low.
REQ-024 With WM_LONG_PRESS_EN: cancel SHALL pulse one cycle on the edge after the counter reaches LONG_PRESS_CYCLES; start_pause SHALL pulse one cycle on the edge after debounced 1->0 only if cancel did not fire during that press; no pulse on press.
REQ-025 Without WM_LONG_PRESS_EN: no duration counter SHALL be synthesized, cancel tied 0, REQ-017 applies.

Verification (DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20)
REQ-026 Reset, raw button held high 10 cycles, macro off -> exactly one start_pause pulse at edge 7; mode_select=00, door_sensor=0, cancel=0 throughout.
REQ-027 Raw button high 3 cycles then low -> no start_pause, counter returns to 0; then bounce 1/0 for 6 cycles ending high -> one pulse 7 edges after final rise.
REQ-028 mode_raw 00->10 -> mode_select=10 at edge 6; mode_raw 10->11 for 2 cycles then 01 steady -> mode_select never shows 11, becomes 01 at edge 6 after the 01 change.
REQ-029 Macro on, button held 30 cycles -> cancel one pulse 20 cycles after debounced rise, no start_pause on release; held 10 cycles -> start_pause one pulse after debounced fall, cancel=0.
REQ-030 door_raw high, reset asserted at edge 4 (mid-count) -> door_sensor stays 0 asynchronously; after reset release door_sensor=1 at edge 6 counted from release.
